// File: rtl/io_peripheral_responder_pkg.sv
// Shared constants for the memory-mapped IO peripheral responder:
// data width, register offsets and the base addresses the CPU routing
// stage uses to generate led_cs / switch_cs.
package io_peripheral_responder_pkg;

    // Width of the IO data path; the routing stage zero-extends to 32 bits.
    localparam int IO_DATA_W = 16;

    // Register offsets, decoded from addr[3:2].
    localparam logic [1:0] OFF_LED  = 2'b00;
    localparam logic [1:0] OFF_SW   = 2'b01;
    localparam logic [1:0] OFF_FLAG = 2'b10;
    localparam logic [1:0] OFF_RSVD = 2'b11;

    // Base addresses decoded upstream into the two chip selects.
    localparam logic [31:0] LED_BASE_ADDR    = 32'hFFFF_F000;
    localparam logic [31:0] SWITCH_BASE_ADDR = 32'hFFFF_F100;

    // Extract the register offset from a byte address.
    function automatic logic [1:0] reg_offset(input logic [31:0] byte_addr);
        return byte_addr[3:2];
    endfunction

endpackage

// File: rtl/io_peripheral_responder_if.sv
// CPU-side IO bus between the address-routing stage (master) and the
// peripheral responder (slave).
interface io_peripheral_responder_if;
    import io_peripheral_responder_pkg::*;

    logic                 led_cs;
    logic                 switch_cs;
    logic                 io_write;
    logic                 io_read;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [IO_DATA_W-1:0] rdata;

    modport master (
        output led_cs, switch_cs, io_write, io_read, addr, wdata,
        input  rdata
    );

    modport slave (
        input  led_cs, switch_cs, io_write, io_read, addr, wdata,
        output rdata
    );

endinterface

// File: rtl/io_peripheral_responder_sw_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for the board switches.
// A new synchronised value is accepted only after it has differed from the
// stable value for DEBOUNCE_CYCLES consecutive cycles. Returning to the
// stable value restarts the count; a different non-stable value does not,
// and the value accepted is whatever sync2 holds on the accepting cycle.
// update is high for the single cycle whose closing edge loads sw_stable.
module io_peripheral_responder_sw_debounce
    import io_peripheral_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IO_DATA_W-1:0] switch_pad,
    output logic [IO_DATA_W-1:0] sw_stable,
    output logic                 update
);

    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IO_DATA_W-1:0] sync1;
    logic [IO_DATA_W-1:0] sync2;
    logic [CNT_W-1:0]     count;

    // Accept when the differing value has survived the full window.
    assign update = (sync2 != sw_stable) && (count == COUNT_LAST);

    // Bring the asynchronous pads into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_pad;
            sync2 <= sync1;
        end
    end

    // Count how long sync2 has differed from sw_stable and accept at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_stable <= '0;
            count     <= '0;
        end else if (sync2 == sw_stable) begin
            count <= '0;
        end else if (update) begin
            sw_stable <= sync2;
            count     <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/io_peripheral_responder.sv
// Peripheral responder for the CPU memory-mapped IO path: a write-loaded
// LED register, debounced switch readback and a sticky switch-change flag
// that is cleared by reading it. Read data is combinational so the
// single-cycle CPU samples it in the same cycle, and is 0 when not selected.
module io_peripheral_responder
    import io_peripheral_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    io_peripheral_responder_if.slave  bus,
    input  logic [IO_DATA_W-1:0]      switch_pad,
    output logic [IO_DATA_W-1:0]      led_out,
    output logic                      sw_changed
);

    logic [1:0]           offset;
    logic                 led_write;
    logic                 sw_read;
    logic                 flag_clear;
    logic [IO_DATA_W-1:0] sw_stable;
    logic                 sw_update;
    logic                 unused_bus_bits;

    assign offset     = reg_offset(bus.addr);
    assign led_write  = bus.led_cs && bus.io_write && (offset == OFF_LED);
    assign sw_read    = bus.switch_cs && bus.io_read;
    assign flag_clear = sw_read && (offset == OFF_FLAG);

    // Address bits outside the offset field and the upper write data are
    // decoded upstream or not meaningful here.
    assign unused_bus_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16]};

    io_peripheral_responder_sw_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sw_debounce (
        .clk        (clk),
        .rst        (rst),
        .switch_pad (switch_pad),
        .sw_stable  (sw_stable),
        .update     (sw_update)
    );

    // LED register: loaded from the low half of the write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out <= '0;
        end else if (led_write) begin
            led_out <= bus.wdata[IO_DATA_W-1:0];
        end
    end

    // Sticky change flag: a new accept outranks a clearing read.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else if (sw_update) begin
            sw_changed <= 1'b1;
        end else if (flag_clear) begin
            sw_changed <= 1'b0;
        end
    end

    // Read mux: registered state only, so a same-cycle write or clear is
    // not yet visible and the old value is returned.
    always_comb begin
        bus.rdata = '0;
        if (sw_read) begin
            case (offset)
                OFF_LED:  bus.rdata = led_out;
                OFF_SW:   bus.rdata = sw_stable;
                OFF_FLAG: bus.rdata = {{(IO_DATA_W-1){1'b0}}, sw_changed};
                default:  bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_peripheral_responder.sv
// Directed bench for io_peripheral_responder with an 8-cycle debounce
// window, so a held pad change reaches sw_stable 10 edges after it is driven.
module tb_io_peripheral_responder;
    import io_peripheral_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switch_pad;
    logic [15:0] led_out;
    logic        sw_changed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_peripheral_responder_if bus ();

    io_peripheral_responder #(
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .switch_pad (switch_pad),
        .led_out    (led_out),
        .sw_changed (sw_changed)
    );

    // Count one comparison and report it if it disagrees.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.led_cs    = 1'b0;
        bus.switch_cs = 1'b0;
        bus.io_write  = 1'b0;
        bus.io_read   = 1'b0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
    endtask

    // Present a read at one offset and check the same-cycle data.
    // The strobe is left asserted; callers idle the bus when needed.
    task automatic read_chk(input string tag, input logic [1:0] off, input logic [15:0] exp);
        bus.switch_cs = 1'b1;
        bus.io_read   = 1'b1;
        bus.addr      = {28'h0, off, 2'b00};
        #1;
        check(tag, {16'h0, bus.rdata}, {16'h0, exp});
    endtask

    task automatic write_led(input logic [31:0] a, input logic [31:0] d);
        bus.led_cs   = 1'b1;
        bus.io_write = 1'b1;
        bus.addr     = a;
        bus.wdata    = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset with all switches high.
        bus_idle();
        switch_pad = 16'hFFFF;
        rst = 1'b1;
        tick();
        tick();
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_flag", {31'h0, sw_changed}, 32'h0);
        for (int off = 0; off < 4; off++) begin
            read_chk("rst_rd", 2'(off), 16'h0);
        end
        bus_idle();
        rst = 1'b0;
        switch_pad = 16'h0000;
        tick();
        tick();

        // 2. LED write and readback.
        write_led(32'h0, 32'hDEAD_A5A5);
        tick();
        bus_idle();
        check("led_wr", {16'h0, led_out}, 32'hA5A5);
        read_chk("led_rd", OFF_LED, 16'hA5A5);
        bus_idle();
        write_led(32'h4, 32'h0000_1234);
        tick();
        check("led_wr_off1", {16'h0, led_out}, 32'hA5A5);
        write_led(32'hC, 32'h0000_4321);
        tick();
        check("led_wr_off3", {16'h0, led_out}, 32'hA5A5);
        bus_idle();
        read_chk("rsvd_rd", OFF_RSVD, 16'h0);
        bus.io_read = 1'b0;
        #1;
        check("rd_no_strobe", {16'h0, bus.rdata}, 32'h0);
        bus_idle();
        bus.io_read = 1'b1;
        #1;
        check("rd_no_cs", {16'h0, bus.rdata}, 32'h0);
        bus_idle();
        write_led(32'h0, 32'h0000_5A5A);
        read_chk("led_rd_during_wr", OFF_LED, 16'hA5A5);
        tick();
        bus_idle();
        check("led_wr2", {16'h0, led_out}, 32'h5A5A);

        // 4. Bounce reject: toggle bit 0 every 3 cycles.
        for (int i = 0; i < 40; i++) begin
            switch_pad = ((i / 3) % 2 == 1) ? 16'h0001 : 16'h0000;
            tick();
        end
        switch_pad = 16'h0000;
        repeat (12) tick();
        read_chk("bounce_sw", OFF_SW, 16'h0);
        bus_idle();
        check("bounce_flag", {31'h0, sw_changed}, 32'h0);

        // 3. Debounce accept after exactly 10 edges.
        tick();
        switch_pad = 16'h00F0;
        repeat (9) tick();
        read_chk("deb_sw_early", OFF_SW, 16'h0);
        bus_idle();
        check("deb_flag_early", {31'h0, sw_changed}, 32'h0);
        tick();
        read_chk("deb_sw", OFF_SW, 16'h00F0);
        bus_idle();
        check("deb_flag", {31'h0, sw_changed}, 32'h1);

        // 5. Read-to-clear.
        read_chk("clr_rd1", OFF_FLAG, 16'h0001);
        tick();
        read_chk("clr_rd2", OFF_FLAG, 16'h0000);
        bus_idle();
        check("clr_flag", {31'h0, sw_changed}, 32'h0);
        tick();
        switch_pad = 16'h00F1;
        repeat (10) tick();
        check("acc2_flag", {31'h0, sw_changed}, 32'h1);
        read_chk("acc2_sw", OFF_SW, 16'h00F1);
        bus_idle();
        tick();
        switch_pad = 16'h00F3;
        repeat (9) tick();
        read_chk("coinc_rd", OFF_FLAG, 16'h0001);
        tick();
        bus_idle();
        check("coinc_flag", {31'h0, sw_changed}, 32'h1);
        read_chk("coinc_sw", OFF_SW, 16'h00F3);
        bus_idle();
        read_chk("clr_rd3", OFF_FLAG, 16'h0001);
        tick();
        bus_idle();
        check("clr_flag2", {31'h0, sw_changed}, 32'h0);

        // 6. Reset while the debounce count is at 5.
        tick();
        switch_pad = 16'h0F00;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        read_chk("mid_rst_sw", OFF_SW, 16'h0);
        bus_idle();
        check("mid_rst_flag", {31'h0, sw_changed}, 32'h0);
        check("mid_rst_led", {16'h0, led_out}, 32'h0);
        rst = 1'b0;
        repeat (9) tick();
        read_chk("post_rst_sw_early", OFF_SW, 16'h0);
        bus_idle();
        check("post_rst_flag_early", {31'h0, sw_changed}, 32'h0);
        tick();
        read_chk("post_rst_sw", OFF_SW, 16'h0F00);
        bus_idle();
        check("post_rst_flag", {31'h0, sw_changed}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_peripheral_responder.md
Name: io_peripheral_responder

Overview:
- Peripheral-side responder for the CPU's memory-mapped IO path.
- Consumes the LED/switch chip selects, IO strobes, address and write data produced by the CPU's IO address-routing stage.
- Drives the board LEDs from a write-loaded register.
- Synchronises and debounces the 16 board switches and returns 16-bit read data to the CPU. The routing stage zero-extends that data to 32 bits.
- Adds a sticky switch-change flag, cleared on read, so software can poll for switch activity.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised switch vector must stay at a new value before it is accepted (10 ms at 100 MHz).
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- led_cs  input  1  LED chip select from the IO routing stage
- switch_cs  input  1  switch chip select from the IO routing stage
- io_write  input  1  IO write strobe
- io_read  input  1  IO read strobe
- addr  input  32  byte address; only addr[3:2] is decoded (register offset)
- wdata  input  32  write data from the register file; only wdata[15:0] is used
- switch_pad  input  16  raw, asynchronous board switches
- led_out  output  16  LED drive, registered
- rdata  output  16  read data to the CPU, combinational from registered state
- sw_changed  output  1  sticky change flag, also visible for an interrupt or debug LED

Behaviour:
- Reset, when rst=1 at a clock edge:
  - led_reg=0, so led_out=0.
  - Both synchroniser stages=0, sw_stable=0, debounce count=0, sw_changed=0.
  - rdata then reflects the reset state: 0 at every offset.
- Register map, selected by addr[3:2]:
  - 00: LED register, read/write.
  - 01: debounced switch value, read-only.
  - 10: {15'b0, sw_changed}, read-to-clear.
  - 11: reserved; reads 0, writes ignored.
- Write:
  - When led_cs & io_write & addr[3:2]==00, led_reg <= wdata[15:0] at the edge. The new value is visible on led_out next cycle (1-cycle latency).
  - Writes to other offsets, or with led_cs=0, have no effect.
- Read:
  - rdata = decode(addr[3:2]) whenever switch_cs & io_read; otherwise rdata=0.
  - Read latency is 0 cycles, so the single-cycle CPU samples it in the same cycle.
- Switch path:
  - 2-flop synchroniser: sync1<=switch_pad, sync2<=sync1.
  - Debounce, applied to the whole vector:
    - If sync2==sw_stable: count<=0.
    - Else if count==DEBOUNCE_CYCLES-1: sw_stable<=sync2, count<=0, set sw_changed.
    - Else: count<=count+1.
  - A change back to the stable value mid-count resets the count; there is no partial acceptance.
  - A further different value mid-count does not reset the count; the value accepted is sync2 at the accepting cycle.
  - Total latency from a pad change to sw_stable is DEBOUNCE_CYCLES+2 cycles.
- Change flag:
  - Set when sw_stable is updated.
  - Cleared at the edge that ends a cycle with switch_cs & io_read & addr[3:2]==10. The read in that cycle returns the pre-clear value.
  - If set and clear coincide, set wins and the flag stays 1.
- Simultaneous events: led_cs and switch_cs asserted together is legal; the write and the read proceed independently. A read of offset 00 in the same cycle as a write to it returns the old LED value.
- Reset mid-operation: rst overrides all other updates in that cycle, including pending debounce counts and flag sets.
- No X or Z outputs: rdata is driven to 0 when not selected, so the routing stage's mux sees a defined value.

Decomposition:
- Shared package or include holds:
  - register offset constants OFF_LED=2'b00, OFF_SW=2'b01, OFF_FLAG=2'b10;
  - IO data width 16;
  - the LED and switch base addresses used by the routing stage.
- One natural sub-module, sw_debounce: synchroniser plus counter, parameterised by DEBOUNCE_CYCLES and CNT_W. It outputs sw_stable and a one-cycle update pulse.
- Register file, decode and flag logic stay in the top module.

Test Plan (bench overrides DEBOUNCE_CYCLES=8):
1. Reset: rst=1 for 2 cycles with switch_pad=16'hFFFF -> led_out=0, rdata=0 at every offset, sw_changed=0.
2. LED write/readback: led_cs=1, io_write=1, addr=0x0, wdata=32'hDEAD_A5A5 for 1 cycle -> led_out=16'hA5A5 the next cycle. Then switch_cs=1, io_read=1, addr=0x0 -> rdata=16'hA5A5. A write to addr=0x4 leaves led_out unchanged.
3. Debounce accept: switch_pad 0->16'h00F0 and held -> sw_stable=16'h00F0 exactly 10 cycles later, sw_changed=1. A read at addr=0x4 returns 16'h00F0.
4. Bounce reject: switch_pad toggles 16'h0000/16'h0001 every 3 cycles for 40 cycles, then returns to 0 -> sw_stable stays 0, sw_changed stays 0.
5. Read-to-clear: with sw_changed=1, read addr=0x8 -> rdata=16'h0001 in that cycle, 0 on the next read. Force an accept in the same cycle as the clearing read -> flag remains 1.
6. Reset mid-debounce: assert rst when count=5 -> sw_stable=0, count=0, no flag set. After release, a held new switch value needs the full 10 cycles again.
